// File: rtl/ddr_sample_reader.sv
// Read-back engine: issues READ bursts on an MCB port, pops the returned words and
// streams each word out as three 10-bit samples with overrange/trigger flags.
module ddr_sample_reader #(
   parameter int unsigned BURST_WORDS  = 64,
   parameter int unsigned ADDR_WIDTH   = 30,
   parameter int unsigned NBURST_WIDTH = 16
) (
   input  logic                    ddr_usrclk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   start_address,
   input  logic [NBURST_WIDTH-1:0] num_bursts,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic                    cmd_en,
   output logic [2:0]              cmd_instr,
   output logic [5:0]              cmd_bl,
   output logic [ADDR_WIDTH-1:0]   cmd_byte_addr,
   input  logic                    cmd_full,
   output logic                    rd_en,
   input  logic [31:0]             rd_data,
   input  logic                    rd_empty,
   input  logic                    rd_overflow,
   input  logic                    rd_error,
   output logic [9:0]              sample_data,
   output logic                    sample_or,
   output logic                    sample_trig,
   output logic                    sample_valid,
   input  logic                    sample_ready,
   output logic                    sample_last
);

   localparam int unsigned CNT_W     = $clog2(BURST_WORDS + 1);
   localparam int unsigned ADDR_STEP = BURST_WORDS * 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMD_WAIT,
      S_DRAIN,
      S_FLUSH
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [NBURST_WIDTH-1:0] bursts_q, bursts_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [31:0]             hold_q, hold_d;
   logic                    hold_valid_q, hold_valid_d;
   logic [1:0]              slot_q, slot_d;
   logic                    last_word_q, last_word_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic                    cmd_en_c;
   logic                    rd_en_c;
   logic                    accept;
   logic                    slot2_accept;

   assign accept       = hold_valid_q & sample_ready;
   assign slot2_accept = accept & (slot_q == 2'd2);

   // Next-state, command/pop strobes and holding-register control
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      bursts_d     = bursts_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      slot_d       = slot_q;
      last_word_d  = last_word_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      error_d      = error_q | rd_overflow | rd_error;
      cmd_en_c     = 1'b0;
      rd_en_c      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               error_d = rd_overflow | rd_error;
               if (num_bursts != '0) begin
                  addr_d   = {start_address[ADDR_WIDTH-1:8], 8'h00};
                  bursts_d = num_bursts;
                  busy_d   = 1'b1;
                  state_d  = S_CMD_WAIT;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_CMD_WAIT: begin
            if (!cmd_full) begin
               cmd_en_c = 1'b1;
               bursts_d = bursts_q - NBURST_WIDTH'(1);
               cnt_d    = '0;
               state_d  = S_DRAIN;
            end
         end
         S_DRAIN: begin
            rd_en_c = ~rd_empty & (~hold_valid_q | slot2_accept)
                      & (cnt_q < CNT_W'(BURST_WORDS));
            if (cnt_q == CNT_W'(BURST_WORDS)) begin
               if (bursts_q != '0) begin
                  addr_d  = addr_q + ADDR_WIDTH'(ADDR_STEP);
                  state_d = S_CMD_WAIT;
               end else begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (!hold_valid_q || slot2_accept) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A pop at slot 2 replaces the word in the same cycle it is consumed
      if (rd_en_c) begin
         hold_d       = rd_data;
         hold_valid_d = 1'b1;
         slot_d       = 2'd0;
         cnt_d        = cnt_q + CNT_W'(1);
         last_word_d  = (bursts_q == '0) && (cnt_q == CNT_W'(BURST_WORDS - 1));
      end else if (accept) begin
         if (slot_q == 2'd2) begin
            hold_valid_d = 1'b0;
            slot_d       = 2'd0;
         end else begin
            slot_d = slot_q + 2'd1;
         end
      end
   end

   always_ff @(posedge ddr_usrclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         bursts_q     <= '0;
         cnt_q        <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         slot_q       <= 2'd0;
         last_word_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         bursts_q     <= bursts_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         slot_q       <= slot_d;
         last_word_q  <= last_word_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   // Sample slot select from the registered holding word
   always_comb begin
      unique case (slot_q)
         2'd0:    sample_data = hold_q[9:0];
         2'd1:    sample_data = hold_q[19:10];
         default: sample_data = hold_q[29:20];
      endcase
   end

   assign sample_or     = hold_q[31];
   assign sample_trig   = hold_q[30];
   assign sample_valid  = hold_valid_q;
   assign sample_last   = hold_valid_q & last_word_q & (slot_q == 2'd2);
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign cmd_en        = cmd_en_c;
   assign cmd_instr     = 3'b001;
   assign cmd_bl        = 6'(BURST_WORDS - 1);
   assign cmd_byte_addr = addr_q;
   assign rd_en         = rd_en_c;

endmodule

// File: tb/tb_ddr_sample_reader.sv
// Directed bench for ddr_sample_reader: an MCB read-FIFO model feeds numbered words,
// and every accepted sample is compared against its expected index.
module tb_ddr_sample_reader;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [29:0] start_address;
   logic [15:0] num_bursts;
   logic        busy, done, error;
   logic        cmd_en;
   logic [2:0]  cmd_instr;
   logic [5:0]  cmd_bl;
   logic [29:0] cmd_byte_addr;
   logic        cmd_full;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_empty;
   logic        rd_overflow, rd_error;
   logic [9:0]  sample_data;
   logic        sample_or, sample_trig, sample_valid, sample_ready, sample_last;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] fifo[$];
   logic [29:0] cmd_log[$];
   int  gen_word, samp_cnt, exp_total, last_cyc, done_cyc, done_cnt;
   bit  busy_seen, ready_toggle, rand_empty, cmd_full_force;
   bit  stall_prev;
   logic [9:0] stall_data;

   ddr_sample_reader dut (
      .ddr_usrclk    (clk),
      .reset_n       (reset_n),
      .start         (start),
      .start_address (start_address),
      .num_bursts    (num_bursts),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .cmd_en        (cmd_en),
      .cmd_instr     (cmd_instr),
      .cmd_bl        (cmd_bl),
      .cmd_byte_addr (cmd_byte_addr),
      .cmd_full      (cmd_full),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_empty      (rd_empty),
      .rd_overflow   (rd_overflow),
      .rd_error      (rd_error),
      .sample_data   (sample_data),
      .sample_or     (sample_or),
      .sample_trig   (sample_trig),
      .sample_valid  (sample_valid),
      .sample_ready  (sample_ready),
      .sample_last   (sample_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment: drive MCB/consumer inputs at negedge, observe just after
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         sample_ready = ready_toggle ? (cyc % 3 == 0) : 1'b1;
         rd_empty     = (fifo.size() == 0) || (rand_empty && $urandom_range(0, 2) == 0);
         rd_data      = (fifo.size() != 0) ? fifo[0] : 32'h0;
         cmd_full     = cmd_full_force;
         #1;
         if (!reset_n) stall_prev = 1'b0;
         if (busy) busy_seen = 1'b1;
         if (cmd_en) begin
            cmd_log.push_back(cmd_byte_addr);
            checks++;
            if ({cmd_full, cmd_instr, cmd_bl} !== {1'b0, 3'b001, 6'd63})
               $display("FAIL cmd_fields: got full=%0b instr=%b bl=%0d, want full=0 instr=001 bl=63",
                        cmd_full, cmd_instr, cmd_bl);
            if ({cmd_full, cmd_instr, cmd_bl} !== {1'b0, 3'b001, 6'd63}) errors++;
            checks++;
            if (fifo.size() !== 0) begin
               errors++;
               $display("FAIL one_outstanding: fifo holds %0d words at cmd_en, want 0", fifo.size());
            end
            for (int k = 0; k < 64; k++) begin
               fifo.push_back({2'b10, 10'(3 * gen_word + 2), 10'(3 * gen_word + 1), 10'(3 * gen_word)});
               gen_word++;
            end
         end
         if (rd_en) begin
            checks++;
            if (rd_empty !== 1'b0) begin
               errors++;
               $display("FAIL pop_empty: rd_en=1 with rd_empty=%b, want rd_empty=0", rd_empty);
            end else begin
               void'(fifo.pop_front());
            end
         end
         if (stall_prev && sample_valid) begin
            checks++;
            if (sample_data !== stall_data) begin
               errors++;
               $display("FAIL stall_stable: data %0d, want held %0d", sample_data, stall_data);
            end
         end
         stall_prev = sample_valid && !sample_ready;
         stall_data = sample_data;
         if (sample_valid && sample_ready) begin
            checks++;
            if ({sample_or, sample_trig, sample_data} !== {1'b1, 1'b0, 10'(samp_cnt)}) begin
               errors++;
               $display("FAIL sample_%0d: or=%b trig=%b data=%0d, want or=1 trig=0 data=%0d",
                        samp_cnt, sample_or, sample_trig, sample_data, samp_cnt % 1024);
            end
            checks++;
            if (sample_last !== (samp_cnt == exp_total - 1)) begin
               errors++;
               $display("FAIL last_%0d: sample_last=%b, want %b", samp_cnt, sample_last,
                        samp_cnt == exp_total - 1);
            end
            if (sample_last) last_cyc = cyc;
            samp_cnt++;
         end
         if (done) begin
            if (done_cyc < 0) done_cyc = cyc;
            done_cnt++;
         end
      end
   end

   task automatic prep(input int total);
      samp_cnt  = 0;
      exp_total = total;
      gen_word  = 0;
      last_cyc  = -1;
      done_cyc  = -1;
      done_cnt  = 0;
      busy_seen = 1'b0;
      cmd_log.delete();
   endtask

   task automatic pulse_start(input logic [29:0] a, input logic [15:0] n);
      @(negedge clk);
      start         = 1'b1;
      start_address = a;
      num_bursts    = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cyc);
      for (int i = 0; i < max_cyc && done_cyc < 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      #2;
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL %s_done: %0d done pulses within %0d cycles, want 1", name, done_cnt, max_cyc);
      end
   endtask

   task automatic check_run(input string name, input int total);
      checks++;
      if (samp_cnt !== total) begin
         errors++;
         $display("FAIL %s_count: %0d samples, want %0d", name, samp_cnt, total);
      end
      checks++;
      if (done_cyc !== last_cyc + 1) begin
         errors++;
         $display("FAIL %s_done_timing: done at cycle %0d, want %0d", name, done_cyc, last_cyc + 1);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy_after: busy=%b, want 0", name, busy);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      checks++;
      if ({busy, done, error, cmd_en, rd_en, sample_valid, sample_last, cmd_byte_addr, sample_data}
          !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b err=%b cmd_en=%b rd_en=%b valid=%b last=%b addr=%h data=%h, want all 0",
                  busy, done, error, cmd_en, rd_en, sample_valid, sample_last, cmd_byte_addr, sample_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_burst();
      prep(192);
      pulse_start(30'h100, 16'd1);
      wait_done("single", 2000);
      check_run("single", 192);
      checks++;
      if (cmd_log.size() !== 1 || cmd_log[0] !== 30'h100) begin
         errors++;
         $display("FAIL single_cmd: %0d cmds first=%h, want 1 cmd at 00000100", cmd_log.size(),
                  cmd_log.size() ? cmd_log[0] : 30'h0);
      end
   endtask

   task automatic test_wrap();
      logic [29:0] exp_a[3];
      exp_a = '{30'h3FFF_FE00, 30'h3FFF_FF00, 30'h0000_0000};
      prep(576);
      pulse_start(30'h3FFF_FE05, 16'd3);
      wait_done("wrap", 3000);
      check_run("wrap", 576);
      checks++;
      if (cmd_log.size() !== 3) begin
         errors++;
         $display("FAIL wrap_ncmd: %0d cmds, want 3", cmd_log.size());
      end
      for (int i = 0; i < 3 && i < cmd_log.size(); i++) begin
         checks++;
         if (cmd_log[i] !== exp_a[i]) begin
            errors++;
            $display("FAIL wrap_addr%0d: %h, want %h", i, cmd_log[i], exp_a[i]);
         end
      end
   endtask

   task automatic test_stall();
      ready_toggle = 1'b1;
      rand_empty   = 1'b1;
      prep(384);
      pulse_start(30'h2000, 16'd2);
      wait_done("stall", 6000);
      check_run("stall", 384);
      ready_toggle = 1'b0;
      rand_empty   = 1'b0;
   endtask

   task automatic test_cmd_full();
      cmd_full_force = 1'b1;
      prep(384);
      pulse_start(30'h1000, 16'd2);
      repeat (20) @(negedge clk);
      #2;
      checks++;
      if (cmd_log.size() !== 0) begin
         errors++;
         $display("FAIL cmdfull_hold: %0d cmds while full, want 0", cmd_log.size());
      end
      cmd_full_force = 1'b0;
      repeat (60) @(negedge clk);
      pulse_start(30'h3000_0000, 16'd7);
      wait_done("cmdfull", 3000);
      check_run("cmdfull", 384);
      checks++;
      if (cmd_log.size() !== 2 || cmd_log[0] !== 30'h1000 || cmd_log[1] !== 30'h1100) begin
         errors++;
         $display("FAIL cmdfull_cmds: %0d cmds first=%h, want 2 cmds 00001000,00001100",
                  cmd_log.size(), cmd_log.size() ? cmd_log[0] : 30'h0);
      end
   endtask

   task automatic test_overflow();
      prep(192);
      pulse_start(30'h400, 16'd1);
      repeat (30) @(negedge clk);
      rd_overflow = 1'b1;
      @(negedge clk);
      rd_overflow = 1'b0;
      wait_done("ovf", 2000);
      check_run("ovf", 192);
      checks++;
      if (error !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: error=%b, want 1", error);
      end
      prep(0);
      pulse_start(30'h0, 16'd0);
      #2;
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: error=%b after start, want 0", error);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_drain();
      prep(192);
      pulse_start(30'h800, 16'd1);
      repeat (20) @(negedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, error, cmd_en, rd_en, sample_valid, sample_last, cmd_byte_addr, sample_data}
          !== '0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b valid=%b rd_en=%b addr=%h data=%h, want all 0",
                  busy, sample_valid, rd_en, cmd_byte_addr, sample_data);
      end
      fifo.delete();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_zero_bursts();
      prep(0);
      pulse_start(30'h500, 16'd0);
      #2;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL zero_done: done=%b the cycle after start, want 1", done);
      end
      repeat (5) @(negedge clk);
      #2;
      checks++;
      if ({cmd_log.size() == 0, busy_seen, done_cnt == 1} !== 3'b101) begin
         errors++;
         $display("FAIL zero_side: cmds=%0d busy_seen=%b done_pulses=%0d, want 0,0,1",
                  cmd_log.size(), busy_seen, done_cnt);
      end
   endtask

   initial begin
      start = 1'b0; start_address = '0; num_bursts = '0;
      rd_overflow = 1'b0; rd_error = 1'b0;
      ready_toggle = 1'b0; rand_empty = 1'b0; cmd_full_force = 1'b0;
      cmd_full = 1'b0; rd_empty = 1'b1; rd_data = '0; sample_ready = 1'b1;
      stall_prev = 1'b0;
      prep(0);
      test_reset();
      test_single_burst();
      test_wrap();
      test_stall();
      test_cmd_full();
      test_overflow();
      test_reset_mid_drain();
      test_zero_bursts();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr_sample_reader.md
Name: ddr_sample_reader

Overview:
- Read-back engine for ADC capture data already stored in LPDDR by the capture path.
- Issues 64-word READ bursts on an MCB read port and pops the returned 32-bit words.
- Unpacks each word into three 10-bit samples with their overrange and trigger flags.
- Presents the samples one at a time on a valid/ready stream to downstream consumers (USB readout, trigger post-processing).

Parameters:
- BURST_WORDS, 64, words per READ burst; cmd_bl = BURST_WORDS-1; address step = BURST_WORDS*4 bytes.
- ADDR_WIDTH, 30, MCB byte address width.
- NBURST_WIDTH, 16, width of the burst-count request.

Ports:
- ddr_usrclk  in  1  MCB user clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin readback; ignored while busy.
- start_address  in  ADDR_WIDTH  first burst byte address; bits [7:0] forced to 0 internally.
- num_bursts  in  NBURST_WIDTH  number of bursts to read.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- error  out  1  sticky rd_overflow|rd_error; cleared on accepted start.
- cmd_en  out  1  MCB command strobe.
- cmd_instr  out  3  constant 3'b001 (READ).
- cmd_bl  out  6  constant BURST_WORDS-1.
- cmd_byte_addr  out  ADDR_WIDTH  burst address.
- cmd_full  in  1  MCB command FIFO full.
- rd_en  out  1  pop MCB read FIFO.
- rd_data  in  32  read word; valid whenever rd_empty=0.
- rd_empty  in  1  read FIFO empty.
- rd_overflow  in  1  MCB read overflow.
- rd_error  in  1  MCB read error.
- sample_data  out  10  unpacked sample.
- sample_or  out  1  word bit 31 (overrange).
- sample_trig  out  1  word bit 30 (trigger status).
- sample_valid  out  1  sample present.
- sample_ready  in  1  consumer accepts.
- sample_last  out  1  final sample of the request.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - busy, done, error, cmd_en, rd_en, sample_valid, sample_last = 0.
  - cmd_byte_addr=0, sample_data=0; holding register empty.
- IDLE:
  - start=1 and num_bursts!=0: latch address {start_address[29:8],8'h00} and burst count, clear error, busy=1 -> CMD_WAIT.
  - start=1 and num_bursts=0: done pulses the next cycle, busy stays 0.
- CMD_WAIT:
  - cmd_full=0: assert cmd_en for exactly one cycle with the current address, decrement remaining bursts, clear word counter -> DRAIN.
  - cmd_full=1: wait.
- DRAIN:
  - rd_en = ~rd_empty & (holding empty | (sample_valid & sample_ready & slot==2)) & word_cnt<BURST_WORDS.
  - On rd_en: rd_data is captured into the holding register, slot=0, word_cnt+1.
  - After BURST_WORDS pops: if bursts remain, address += 256 (mod 2^ADDR_WIDTH, wrap to 0) -> CMD_WAIT; else -> FLUSH.
- FLUSH:
  - Waits for the final held word to be fully consumed.
  - Then done=1 for one cycle, busy=0 -> IDLE.
- Unpack:
  - slot0 = bits[9:0], slot1 = bits[19:10], slot2 = bits[29:20].
  - sample_or and sample_trig are the word's bits 31/30, identical for all three slots.
  - sample_data and flags are driven from registers and held stable while sample_valid & ~sample_ready.
  - Accept (valid&ready): slot advances 0->1->2. Accept at slot 2 either reloads the holding register the same cycle (rd_en) or empties it.
  - Zero-bubble throughput: 1 sample/cycle with ready=1 and the FIFO non-empty.
- sample_last = 1 on slot 2 of the last word of the last burst.
- error:
  - Set on any cycle with rd_overflow|rd_error.
  - Holds until the next accepted start; does not stop the FSM.
- Never pop while rd_empty=1.
- Never issue cmd_en while cmd_full=1.
- At most one burst outstanding.
- start during busy is ignored, with no effect on address or counters.

Test Plan:
- num_bursts=1, start_address=0x100, ready=1, FIFO returns 64 words 0x8000_0000|{k+2,k+1,k}:
  - exactly one cmd_en with addr=0x100, bl=63, instr=001;
  - 192 samples 0,1,2,... all with or=1, trig=0;
  - sample_last on #192, done one cycle later.
- num_bursts=3, start_address=0x3FFF_FE05:
  - cmd addrs 0x3FFF_FE00, 0x3FFF_FF00, 0x0000_0000 (wrap);
  - 576 samples.
- sample_ready toggling 1,0,0 and rd_empty randomly high:
  - sample stream is identical to the ready=1 case;
  - sample_data is stable while stalled; no pop while empty.
- cmd_full=1 for 20 cycles at CMD_WAIT:
  - cmd_en stays 0 throughout, then a single pulse.
  - start pulsed mid-run is ignored.
- rd_overflow pulsed for 1 cycle mid-burst:
  - error=1 until the next start, where it clears; run still completes.
- reset_n low during DRAIN: all outputs zero immediately. num_bursts=0 start: done pulse, no cmd_en.
